// File: rtl/pwm_meter_pkg.sv
// Shared definitions for the PWM duty meter and its restoring divider.
//   DUTY_W    : width of the duty level (0..15 count domain)
//   DIV_ITER  : number of restoring-division iterations (one quotient bit each)
//   ITER_W    : width of the divider iteration counter
//   div_state_e : divider sequencing states
package pwm_meter_pkg;

  localparam int DUTY_W   = 4;
  localparam int DIV_ITER = 4;
  localparam int ITER_W   = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider producing floor(16*H/P) for H < P.
// One quotient bit is resolved per RUN cycle, MSB first; the partial
// remainder starts at H and is doubled before each trial subtraction.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-low
//   start in   begin a division; accepted only while idle
//   H     in   CNT_W  dividend (high time), must be < P
//   P     in   CNT_W  divisor (period)
//   q     out  DUTY_W quotient; meaningful in the cycle done is high
//   done  out  high during the last iteration (q holds the final result)
//   busy  out  high from the cycle after start through the DONE cycle
module pwm_duty_div
  import pwm_meter_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  H,
  input  logic [CNT_W-1:0]  P,
  output logic [DUTY_W-1:0] q,
  output logic              done,
  output logic              busy
);

  div_state_e          state;
  logic [CNT_W:0]      rem;
  logic [CNT_W-1:0]    dvs;
  logic [DUTY_W-2:0]   qacc;
  logic [ITER_W-1:0]   iter;

  logic [CNT_W:0]      rem_sh;
  logic [CNT_W:0]      rem_nx;
  logic                ge;
  logic [DUTY_W-1:0]   q_nx;

  // Trial subtraction for the current iteration. Because rem < P is
  // invariant, the doubled remainder always fits in CNT_W+1 bits.
  always_comb begin
    rem_sh = rem << 1;
    ge     = (rem_sh >= {1'b0, dvs});
    rem_nx = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;
    q_nx   = {qacc, ge};
  end

  // The final quotient bit is combinational so the result is usable in
  // the same cycle the last iteration runs; this keeps the overall
  // rise-to-valid latency at five cycles.
  assign q    = q_nx;
  assign done = (state == DIV_RUN) && (iter == ITER_W'(DIV_ITER - 1));
  assign busy = (state != DIV_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= DIV_IDLE;
      rem   <= '0;
      dvs   <= '0;
      qacc  <= '0;
      iter  <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            state <= DIV_RUN;
            rem   <= {1'b0, H};
            dvs   <= P;
            qacc  <= '0;
            iter  <= '0;
          end
        end
        DIV_RUN: begin
          rem  <= rem_nx;
          qacc <= q_nx[DUTY_W-2:0];
          iter <= iter + ITER_W'(1);
          if (done) begin
            state <= DIV_DONE;
          end
        end
        // One trailing busy cycle so the divider window spans five cycles.
        DIV_DONE: begin
          state <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty/period meter. Synchronizes an asynchronous PWM input, times
// the period and high interval between rising edges, converts the ratio
// to a 4-bit duty level and flags lines that stop toggling.
//
// Ports:
//   clk     in   system clock, single domain
//   rst     in   synchronous reset, active-low
//   pwm_in  in   asynchronous PWM input
//   duty    out  DUTY_W last measured duty level, floor(16*H/P)
//   period  out  CNT_W  last measured period P in cycles (0 after timeout)
//   valid   out  one-cycle pulse when duty/period update
//   stuck   out  high while no rising edge has been seen for TMO cycles
//   ovr     out  one-cycle pulse when a measurement is dropped (divider busy)
module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic              valid,
  output logic              stuck,
  output logic              ovr
);

  localparam logic [CNT_W-1:0] TMO = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl;
  logic                   lvl_d;
  logic                   rise;

  logic [CNT_W-1:0]       pc;
  logic [CNT_W-1:0]       hc;
  logic                   armed;
  logic [CNT_W-1:0]       p_cap;

  logic                   start;
  logic                   tmo;
  logic [DUTY_W-1:0]      div_q;
  logic                   div_done;
  logic                   div_busy;

  // Counters stick at TMO instead of wrapping, so a dead line can never
  // alias into a short bogus period.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    if (v == TMO) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, inc};
  endfunction

  // Input synchronizer; lvl is the last stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      lvl_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      lvl_d  <= lvl;
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~lvl_d;

  // A measurement is only taken on an armed rise with the divider free.
  // The timeout is suppressed by a coincident rise and fires only once
  // per stuck episode (stuck gates it until the next rise).
  assign start = rise & armed & ~div_busy;
  assign tmo   = (pc == TMO) & ~rise & ~stuck;

  pwm_duty_div #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .H     (hc),
    .P     (pc),
    .q     (div_q),
    .done  (div_done),
    .busy  (div_busy)
  );

  // Counters, arming, timeout and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc     <= '0;
      hc     <= '0;
      armed  <= 1'b0;
      p_cap  <= '0;
      duty   <= '0;
      period <= '0;
      valid  <= 1'b0;
      stuck  <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      valid <= 1'b0;
      ovr   <= 1'b0;

      if (rise) begin
        // The rise cycle itself is the first high cycle of the new period.
        pc    <= CNT_W'(1);
        hc    <= CNT_W'(1);
        stuck <= 1'b0;
        if (armed) begin
          if (div_busy) begin
            ovr <= 1'b1;
          end else begin
            p_cap <= pc;
          end
        end else begin
          armed <= 1'b1;
        end
      end else begin
        pc <= sat_inc(pc, 1'b1);
        hc <= sat_inc(hc, lvl);
      end

      if (tmo) begin
        stuck  <= 1'b1;
        duty   <= {DUTY_W{lvl}};
        period <= '0;
        valid  <= 1'b1;
        armed  <= 1'b0;
      end

      // Cannot coincide with tmo: a division ends five cycles after a
      // rise, long before pc can reach TMO.
      if (div_done) begin
        duty   <= div_q;
        period <= p_cap;
        valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed testbench for pwm_duty_meter with CNT_W=8 (TMO=255).
module tb_pwm_duty_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pwm_in = 1'b0;
  logic [3:0] duty;
  logic [7:0] period;
  logic       valid;
  logic       stuck;
  logic       ovr;

  int vectors     = 0;
  int miscompares = 0;

  int         cyc = 0;
  int         n_valid = 0;
  int         n_ovr = 0;
  int         last_valid_cyc = 0;
  logic [3:0] last_duty = '0;
  logic [7:0] last_period = '0;
  int         last_rise_cyc = 0;
  int         base_v = 0;
  int         base_o = 0;

  pwm_duty_meter #(
    .CNT_W       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .duty   (duty),
    .period (period),
    .valid  (valid),
    .stuck  (stuck),
    .ovr    (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_valid        <= n_valid + 1;
      last_duty      <= duty;
      last_period    <= period;
      last_valid_cyc <= cyc;
    end
    if (ovr) begin
      n_ovr <= n_ovr + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold pwm_in at v for n cycles; returns just after a rising clock edge.
  task automatic tick(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pwm(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      last_rise_cyc = cyc;
      tick(1'b1, hi);
      tick(1'b0, lo);
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    tick(1'b0, 3);
    chk("rst_duty",   int'(duty),   0);
    chk("rst_period", int'(period), 0);
    chk("rst_valid",  int'(valid),  0);
    chk("rst_stuck",  int'(stuck),  0);
    chk("rst_ovr",    int'(ovr),    0);

    // Stuck low from reset: single timeout, duty 0, no wrap
    rst = 1'b1;
    tick(1'b0, 250);
    chk("lo_stuck_early", int'(stuck), 0);
    tick(1'b0, 50);
    chk("lo_stuck",       int'(stuck),  1);
    chk("lo_valid_cnt",   n_valid,      1);
    chk("lo_duty",        int'(duty),   0);
    chk("lo_period",      int'(period), 0);

    // 4/12: first rise clears stuck and only arms
    base_v = n_valid;
    pwm(4, 12, 1);
    chk("p4_stuck_clr", int'(stuck), 0);
    chk("p4_arm_only",  n_valid,     base_v);
    pwm(4, 12, 4);
    chk("p4_valid_cnt", n_valid,                        base_v + 4);
    chk("p4_duty",      int'(last_duty),                4);
    chk("p4_period",    int'(last_period),              16);
    chk("p4_latency",   last_valid_cyc - last_rise_cyc, 7);

    // Other duty ratios
    pwm(50, 50, 3);
    chk("p50_duty",   int'(last_duty),   8);
    chk("p50_period", int'(last_period), 100);
    pwm(15, 1, 3);
    chk("p15_duty",   int'(last_duty),   15);
    chk("p15_period", int'(last_period), 16);
    pwm(1, 99, 3);
    chk("p1_duty",    int'(last_duty),   0);
    chk("p1_period",  int'(last_period), 100);

    // Stuck high after a valid measurement
    base_v = n_valid;
    last_rise_cyc = cyc;
    tick(1'b1, 250);
    chk("hi_stuck_early", int'(stuck), 0);
    tick(1'b1, 50);
    chk("hi_stuck",     int'(stuck),                    1);
    chk("hi_duty",      int'(duty),                     15);
    chk("hi_period",    int'(period),                   0);
    chk("hi_valid_cnt", n_valid,                        base_v + 2);
    chk("hi_tmo_cyc",   last_valid_cyc - last_rise_cyc, 258);

    // Recovery: first rise re-arms only, second measures
    tick(1'b0, 5);
    base_v = n_valid;
    pwm(4, 12, 1);
    chk("rec_stuck_clr", int'(stuck), 0);
    chk("rec_arm_only",  n_valid,     base_v);
    pwm(4, 12, 1);
    chk("rec_valid_cnt", n_valid,         base_v + 1);
    chk("rec_duty",      int'(last_duty), 4);

    // Period shorter than the busy window: every other rise dropped
    base_v = n_valid;
    base_o = n_ovr;
    pwm(2, 2, 20);
    tick(1'b0, 10);
    chk("ovr_cnt",       n_ovr,             base_o + 10);
    chk("ovr_valid_cnt", n_valid,           base_v + 10);
    chk("ovr_duty",      int'(last_duty),   8);
    chk("ovr_period",    int'(last_period), 4);

    // Reset at rise+2 aborts the division
    base_v = n_valid;
    tick(1'b1, 4);
    rst = 1'b0;
    tick(1'b0, 1);
    rst = 1'b1;
    tick(1'b0, 15);
    chk("abort_no_valid", n_valid,      base_v);
    chk("abort_duty",     int'(duty),   0);
    chk("abort_period",   int'(period), 0);
    chk("abort_stuck",    int'(stuck),  0);
    chk("abort_ovr",      int'(ovr),    0);
    pwm(4, 12, 1);
    chk("abort_arm_only", n_valid, base_v);
    pwm(4, 12, 1);
    chk("abort_valid_cnt", n_valid,           base_v + 1);
    chk("abort_re_duty",   int'(last_duty),   4);
    chk("abort_re_period", int'(last_period), 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
